// File: rtl/echo_tof_capture_if.sv
// Result channel from the echo timestamper to the distance/beamforming stage.
// The producer holds tof_out/timeout_out stable while tof_valid_out is high and tof_ready_in is low.
interface echo_tof_capture_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic [COUNT_WIDTH-1:0] tof_out;
  logic                   timeout_out;
  logic                   tof_valid_out;
  logic                   tof_ready_in;

  modport master (
    output tof_out,
    output timeout_out,
    output tof_valid_out,
    input  tof_ready_in
  );

  modport slave (
    input  tof_out,
    input  timeout_out,
    input  tof_valid_out,
    output tof_ready_in
  );
endinterface

// File: rtl/echo_tof_capture.sv
// Single-ping ultrasonic ranger: trigger, blank, listen, then report the first echo
// rising edge as ticks since ping start (or a timeout) over a valid/ready channel.
module echo_tof_capture #(
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned TRIG_CYCLES   = 1000,
  parameter int unsigned BLANK_TICKS   = 100,
  parameter int unsigned TIMEOUT_TICKS = 23200
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   echo_in,
  output logic                   trig_out,
  output logic                   busy_out,
  echo_tof_capture_if.master     res
);

  typedef enum logic [2:0] {IDLE, TRIG, BLANK, LISTEN, HOLD} state_t;

  localparam int unsigned            TRIG_W      = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [TRIG_W-1:0]      TRIG_LAST   = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] BLANK_LIM   = COUNT_WIDTH'(BLANK_TICKS);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIM = COUNT_WIDTH'(TIMEOUT_TICKS);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] start_cnt_q, start_cnt_d;
  logic [TRIG_W-1:0]      trig_cnt_q, trig_cnt_d;
  logic [COUNT_WIDTH-1:0] tof_q, tof_d;
  logic                   timeout_q, timeout_d;
  logic                   s1, s2, s3;
  logic                   echo_edge;
  logic [COUNT_WIDTH-1:0] elapsed;

  // Modular subtraction keeps the measurement correct across a counter wrap.
  assign elapsed   = count_in - start_cnt_q;
  assign echo_edge = s2 & ~s3;

  // NOTE: every flop here uses <= so all state updates see pre-edge values,
  // which is what makes s1->s2->s3 a shift chain rather than a single wire.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      start_cnt_q <= '0;
      trig_cnt_q  <= '0;
      tof_q       <= '0;
      timeout_q   <= 1'b0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      trig_cnt_q  <= trig_cnt_d;
      tof_q       <= tof_d;
      timeout_q   <= timeout_d;
      s1          <= echo_in;
      s2          <= s1;
      s3          <= s2;
    end
  end

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    trig_cnt_d  = trig_cnt_q;
    tof_d       = tof_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          start_cnt_d = count_in;
          trig_cnt_d  = '0;
          state_d     = TRIG;
        end
      end
      TRIG: begin
        if (trig_cnt_q == TRIG_LAST) state_d = BLANK;
        else                         trig_cnt_d = trig_cnt_q + TRIG_W'(1);
      end
      BLANK: begin
        if (elapsed >= BLANK_LIM) state_d = LISTEN;
      end
      LISTEN: begin
        // An echo arriving on the timeout cycle still counts as a hit.
        if (echo_edge) begin
          tof_d     = elapsed;
          timeout_d = 1'b0;
          state_d   = HOLD;
        end else if (elapsed >= TIMEOUT_LIM) begin
          tof_d     = TIMEOUT_LIM;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (res.tof_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign trig_out          = (state_q == TRIG);
  assign busy_out          = (state_q != IDLE);
  assign res.tof_valid_out = (state_q == HOLD);
  assign res.tof_out       = tof_q;
  assign res.timeout_out   = timeout_q;

endmodule

// File: tb/tb_echo_tof_capture.sv
// Randomized and directed pings against a timeline model: echo levels are kept per
// clock edge relative to ping start and the expected capture edge is derived from them.
module tb_echo_tof_capture;
  localparam int W     = 8;
  localparam int TRIG  = 4;
  localparam int BLANK = 10;
  localparam int TMO   = 200;
  localparam int ELEN  = TMO + 40;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] count = '0;
  logic         echo = 1'b0;
  logic         trig, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Echo level sampled at edge j (relative to the start edge) lives at index j+3.
  bit e_lvl [0:ELEN-1];

  echo_tof_capture_if #(.COUNT_WIDTH(W)) res_if ();

  echo_tof_capture #(
    .COUNT_WIDTH  (W),
    .TRIG_CYCLES  (TRIG),
    .BLANK_TICKS  (BLANK),
    .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .start_in (start),
    .count_in (count),
    .echo_in  (echo),
    .trig_out (trig),
    .busy_out (busy),
    .res      (res_if)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit echo_at(input int j);
    int i;
    i = j + 3;
    if (i < 0) i = 0;
    if (i > ELEN - 1) i = ELEN - 1;
    return e_lvl[i];
  endfunction

  task automatic fill(input int from_j, input bit v);
    for (int i = from_j + 3; i < ELEN; i++) if (i >= 0) e_lvl[i] = v;
  endtask

  // Listening decisions start one edge after blanking is over; an echo first sampled
  // high at edge k (low at k-1) is taken at edge k+2; the echo beats the timeout.
  task automatic model(output int jc, output int tof, output bit to);
    int first;
    first = ((TRIG + 1 > BLANK) ? TRIG + 1 : BLANK) + 1;
    jc = -1; tof = 0; to = 1'b0;
    for (int j = first; j < ELEN; j++) begin
      if (echo_at(j - 2) && !echo_at(j - 3)) begin
        jc = j; tof = j; to = 1'b0; break;
      end
      if (j >= TMO) begin
        jc = j; tof = TMO; to = 1'b1; break;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    count = count + 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trig"},  32'(trig), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_valid"}, 32'(res_if.tof_valid_out), 0);
    check({tag, "_tof"},   32'(res_if.tof_out), 0);
    check({tag, "_to"},    32'(res_if.timeout_out), 0);
  endtask

  // rst_mode: 0 = full ping, 1 = reset during TRIG, 2 = reset during HOLD.
  task automatic run_ping(input int s, input int hold, input int rst_mode);
    int  jc, etof, n;
    bit  eto, found;
    model(jc, etof, eto);
    found = 1'b0;
    res_if.tof_ready_in = (hold == 0);
    tick(); count = W'(s - 3); echo = echo_at(-3); start = 1'b0;
    tick(); echo = echo_at(-2);
    tick(); echo = echo_at(-1);
    tick(); echo = echo_at(0); start = 1'b1;
    for (int j = 1; j <= ELEN + 5 && !found; j++) begin
      tick();
      n = j - 1;
      if (n <= TRIG + 1) begin
        check("trig_shape", 32'(trig), 32'(n < TRIG));
        check("busy_ping",  32'(busy), 1);
      end
      if (rst_mode == 1 && n == 2) begin
        rst = 1'b0; start = 1'b0;
        tick();
        check_zero("rst_trig");
        rst = 1'b1;
        return;
      end
      if (res_if.tof_valid_out) begin
        found = 1'b1;
        check("capture_edge", 32'(n), 32'(jc));
        check("tof",          32'(res_if.tof_out), 32'(etof));
        check("timeout",      32'(res_if.timeout_out), 32'(eto));
      end
      echo  = echo_at(j);
      start = ($urandom_range(0, 3) == 0);
    end
    if (!found) begin
      check("valid_seen", 0, 1);
      return;
    end
    if (rst_mode == 2) begin
      rst = 1'b0; start = 1'b0;
      tick();
      check_zero("rst_hold");
      rst = 1'b1;
      return;
    end
    for (int h = 1; h <= hold; h++) begin
      tick();
      check("bp_valid",   32'(res_if.tof_valid_out), 1);
      check("bp_tof",     32'(res_if.tof_out), 32'(etof));
      check("bp_timeout", 32'(res_if.timeout_out), 32'(eto));
      res_if.tof_ready_in = (h == hold);
      start = ($urandom_range(0, 3) == 0);
    end
    tick();
    check("xfer_valid",   32'(res_if.tof_valid_out), 0);
    check("xfer_busy",    32'(busy), 0);
    check("keep_tof",     32'(res_if.tof_out), 32'(etof));
    check("keep_timeout", 32'(res_if.timeout_out), 32'(eto));
    start = 1'b0;
    res_if.tof_ready_in = $urandom_range(0, 1);
    tick();
    check("no_requeue_busy",  32'(busy), 0);
    check("no_requeue_valid", 32'(res_if.tof_valid_out), 0);
  endtask

  initial begin
    int s, hold, ntog, t;
    bit lvl;
    res_if.tof_ready_in = 1'b1;
    rst = 1'b0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b1;
    tick();
    check_zero("idle");

    // Normal echo at count 70 from a start at 20.
    fill(-3, 1'b0); fill(50, 1'b1);
    run_ping(20, 0, 0);
    // Counter wraps mid-ping: start 250, echo sampled high at count 40.
    fill(-3, 1'b0); fill(46, 1'b1);
    run_ping(250, 0, 0);
    // Pulse inside blanking, real echo later.
    fill(-3, 1'b0); fill(5, 1'b1); fill(7, 1'b0); fill(60, 1'b1);
    run_ping(30, 0, 0);
    // Echo stuck high from before the ping.
    fill(-3, 1'b1);
    run_ping(100, 0, 0);
    // No echo at all.
    fill(-3, 1'b0);
    run_ping(5, 0, 0);
    // Echo taken on the exact cycle the timeout is reached.
    fill(-3, 1'b0); fill(TMO - 2, 1'b1);
    run_ping(77, 0, 0);
    // Backpressure for 15 cycles.
    fill(-3, 1'b0); fill(40, 1'b1);
    run_ping(140, 15, 0);
    // Reset during TRIG, then during HOLD, then a fresh ping.
    fill(-3, 1'b0); fill(30, 1'b1);
    run_ping(60, 0, 1);
    run_ping(60, 0, 2);
    run_ping(200, 0, 0);

    for (int p = 0; p < 40; p++) begin
      lvl = ($urandom_range(0, 4) == 0);
      fill(-3, lvl);
      ntog = $urandom_range(0, 3);
      for (int k = 0; k < ntog; k++) begin
        t = $urandom_range(0, TMO + 5);
        fill(t, !echo_at(t));
      end
      s    = $urandom_range(0, 255);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      run_ping(s, hold, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
